// File: rtl/tl45_register_read_fwdn.sv
// tl45 register-read stage with prioritised operand forwarding and load-use hazard handling.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_pipe_stall/o_pipe_stall downstream stall in; stall out (downstream stall OR hazard)
//   i_pipe_flush/o_pipe_flush flush request, passed straight through
//   i_valid, i_opcode, i_ri, i_dr, i_sr1, i_sr2, i_imm32, i_pc, i_decode_err  decoded instruction
//   o_dprf_read_a1/a2         DPRF read addresses (combinational copies of i_sr1/i_sr2)
//   i_dprf_d1/d2              DPRF read data
//   i_fwd_reg/data/valid/pending  forwarding buses; bus 0 is the youngest producer
//   o_valid .. o_decode_err   registered stage buffer feeding the ALU
//   o_hazard                  combinational load-use hazard
//   o_hazard_count            saturating count of hazard stall cycles
module tl45_register_read_fwdn #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned RAW           = 4,
    parameter int unsigned NUM_FWD       = 2,
    parameter logic [4:0]  BRANCH_OPCODE = 5'h0C
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_pipe_stall,
    output logic                    o_pipe_stall,
    input  logic                    i_pipe_flush,
    output logic                    o_pipe_flush,
    input  logic                    i_valid,
    input  logic [4:0]              i_opcode,
    input  logic                    i_ri,
    input  logic [RAW-1:0]          i_dr,
    input  logic [RAW-1:0]          i_sr1,
    input  logic [RAW-1:0]          i_sr2,
    input  logic [XLEN-1:0]         i_imm32,
    input  logic [XLEN-1:0]         i_pc,
    input  logic                    i_decode_err,
    output logic [RAW-1:0]          o_dprf_read_a1,
    output logic [RAW-1:0]          o_dprf_read_a2,
    input  logic [XLEN-1:0]         i_dprf_d1,
    input  logic [XLEN-1:0]         i_dprf_d2,
    input  logic [NUM_FWD*RAW-1:0]  i_fwd_reg,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD-1:0]      i_fwd_pending,
    output logic                    o_valid,
    output logic [4:0]              o_opcode,
    output logic [RAW-1:0]          o_dr,
    output logic [RAW-1:0]          o_jmp_cond,
    output logic [XLEN-1:0]         o_sr1_val,
    output logic [XLEN-1:0]         o_sr2_val,
    output logic [XLEN-1:0]         o_target_address_offset,
    output logic [XLEN-1:0]         o_pc,
    output logic                    o_decode_err,
    output logic                    o_hazard,
    output logic [31:0]             o_hazard_count
);

    logic            w_need1, w_need2, w_hazard;
    logic [XLEN-1:0] w_sr1_val, w_sr2_val;

    logic            r_valid, r_decode_err;
    logic [4:0]      r_opcode;
    logic [RAW-1:0]  r_dr, r_jmp_cond;
    logic [XLEN-1:0] r_sr1_val, r_sr2_val, r_offset, r_pc;
    logic [31:0]     r_hazard_count;

    // Walk from lowest to highest priority so the youngest matching bus wins, including
    // its pending flag: an older ready value never hides a younger pending producer.
    always_comb begin
        w_need1   = 1'b0;
        w_need2   = 1'b0;
        w_sr1_val = i_dprf_d1;
        w_sr2_val = i_dprf_d2;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_reg[k*RAW +: RAW] == i_sr1) && (i_sr1 != '0)) begin
                w_need1   = i_fwd_pending[k];
                w_sr1_val = i_fwd_data[k*XLEN +: XLEN];
            end
            if (i_fwd_valid[k] && (i_fwd_reg[k*RAW +: RAW] == i_sr2) && (i_sr2 != '0)) begin
                w_need2   = i_fwd_pending[k];
                w_sr2_val = i_fwd_data[k*XLEN +: XLEN];
            end
        end
        if (i_ri) begin
            w_need2   = 1'b0;
            w_sr2_val = i_imm32;
        end
    end

    assign w_hazard       = i_valid & ~i_decode_err & (w_need1 | w_need2);
    assign o_hazard       = w_hazard;
    assign o_pipe_stall   = i_pipe_stall | w_hazard;
    assign o_pipe_flush   = i_pipe_flush;
    assign o_dprf_read_a1 = i_sr1;
    assign o_dprf_read_a2 = i_sr2;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_pipe_flush || i_decode_err) begin
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_dr         <= '0;
            r_jmp_cond   <= '0;
            r_sr1_val    <= '0;
            r_sr2_val    <= '0;
            r_offset     <= '0;
            r_pc         <= '0;
            // Flush outranks decode error, so only an unflushed error is recorded.
            r_decode_err <= ~i_reset & ~i_pipe_flush & i_decode_err;
        end else if (i_pipe_stall) begin
            // hold
        end else if (w_hazard) begin
            // Bubble; PC and offset are left as they were.
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_dr         <= '0;
            r_jmp_cond   <= '0;
            r_sr1_val    <= '0;
            r_sr2_val    <= '0;
            r_decode_err <= 1'b0;
        end else begin
            r_valid      <= i_valid;
            r_opcode     <= i_opcode;
            r_pc         <= i_pc;
            r_offset     <= i_imm32;
            r_sr1_val    <= w_sr1_val;
            r_sr2_val    <= w_sr2_val;
            r_decode_err <= 1'b0;
            if (i_opcode == BRANCH_OPCODE) begin
                r_dr       <= '0;
                r_jmp_cond <= i_dr;
            end else begin
                r_dr       <= i_dr;
                r_jmp_cond <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hazard_count <= '0;
        end else if (w_hazard && !i_pipe_flush && (r_hazard_count != 32'hFFFF_FFFF)) begin
            r_hazard_count <= r_hazard_count + 32'd1;
        end
    end

    assign o_valid                 = r_valid;
    assign o_opcode                = r_opcode;
    assign o_dr                    = r_dr;
    assign o_jmp_cond              = r_jmp_cond;
    assign o_sr1_val               = r_sr1_val;
    assign o_sr2_val               = r_sr2_val;
    assign o_target_address_offset = r_offset;
    assign o_pc                    = r_pc;
    assign o_decode_err            = r_decode_err;
    assign o_hazard_count          = r_hazard_count;

endmodule

// File: doc/tl45_register_read_fwdn.md
Name: tl45_register_read_fwdn

Overview:
Parametrised next-generation register-read stage for the tl45 pipeline. It sits between decode and ALU. It reads the DPRF and resolves operands across NUM_FWD prioritised forwarding buses. New in this generation: per-bus valid and pending flags, load-use hazard detection with stall and bubble insertion, an explicit valid bit on the stage buffer, and a saturating hazard-cycle counter.

Parameters:
XLEN, 32, data/immediate/PC width
RAW, 4, register address width (register 0 reads as zero and never forwards)
NUM_FWD, 2, number of forwarding buses; bus 0 is highest priority (youngest producer)
BRANCH_OPCODE, 5'h0C, opcode whose i_dr field is a jump condition

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_pipe_stall  in  1  downstream stall
o_pipe_stall  out  1  i_pipe_stall OR hazard
i_pipe_flush  in  1  flush request
o_pipe_flush  out  1  equals i_pipe_flush
i_valid  in  1  input slot holds a real instruction
i_opcode  in  5  opcode
i_ri  in  1  1 = SR2 replaced by immediate
i_dr, i_sr1, i_sr2  in  RAW each  destination/condition and source addresses
i_imm32, i_pc  in  XLEN each  immediate and PC
i_decode_err  in  1  decode error
o_dprf_read_a1, o_dprf_read_a2  out  RAW each  equal i_sr1, i_sr2 (combinational)
i_dprf_d1, i_dprf_d2  in  XLEN each  DPRF read data
i_fwd_reg  in  NUM_FWD*RAW  bus k register at bits [k*RAW +: RAW]
i_fwd_data  in  NUM_FWD*XLEN  bus k data
i_fwd_valid  in  NUM_FWD  bus k carries a writer
i_fwd_pending  in  NUM_FWD  bus k writer's value not yet available (e.g. load)
o_valid  out  1  buffer holds a real instruction
o_opcode  out  5; o_dr, o_jmp_cond  out  RAW each
o_sr1_val, o_sr2_val, o_target_address_offset, o_pc  out  XLEN each
o_decode_err  out  1
o_hazard  out  1  combinational hazard indication
o_hazard_count  out  32  saturating count of hazard stall cycles

Behaviour:
- Reset value of every registered output is 0, including o_hazard_count.
- Operand resolution for SRx (x=1,2):
  - Find the lowest k with i_fwd_valid[k] and i_fwd_reg[k]==SRx and SRx!=0.
  - Hit and not pending: value is the bus k data.
  - Hit and pending: raises need_x.
  - No hit: value is the DPRF data.
  - SR2 with i_ri=1: value is i_imm32 and never raises need_2.
  - A lower-priority non-pending match never overrides a higher-priority pending one.
- o_hazard = i_valid & !i_decode_err & (need_1 | need_2). o_pipe_stall = i_pipe_stall | o_hazard.
- Update priority per clock, highest first:
  1. i_reset: clear all outputs and the counter.
  2. i_pipe_flush: clear the buffer (o_valid=0, opcode/dr/vals/pc=0); o_decode_err<=0. The counter is unchanged.
  3. i_decode_err: clear the buffer; o_decode_err<=1.
  4. i_pipe_stall: hold all outputs.
  5. o_hazard: insert a bubble (o_valid=0, o_opcode=0, o_dr=0, o_jmp_cond=0, vals=0). o_decode_err<=0.
  6. Otherwise load: o_valid<=i_valid, o_opcode, o_pc, o_target_address_offset<=i_imm32, resolved values, o_decode_err<=0.
     - Opcode == BRANCH_OPCODE: o_dr<=0, o_jmp_cond<=i_dr.
     - Else: o_dr<=i_dr, o_jmp_cond<=0.
- Counter: increments when o_hazard & !i_pipe_flush & !i_reset, including cycles that also carry i_pipe_stall. It saturates at 32'hFFFFFFFF.
- Latency is 1 cycle. A hazard persists while the pending flag stays set; the bubble repeats each cycle and the upstream stage is held by o_pipe_stall.
- Flush and hazard in the same cycle: flush wins.
- Reset mid-hazard: buffer and counter clear.

Test Plan:
1. Priority: sr1=3, bus0 {reg 3, data 0xAAAA0000, valid}, bus1 {reg 3, data 0x11, valid}, no stall -> next cycle o_sr1_val=0xAAAA0000, o_valid=1.
2. Zero register: sr1=0, bus0 {reg 0, data 0xDEAD, valid}, DPRF d1=0 -> o_sr1_val=0 and no hazard.
3. Load-use: sr2=5, i_ri=0, bus0 {reg 5, pending} for 2 cycles, then pending=0 with data 0x42.
   - o_pipe_stall=1 for 2 cycles and 2 bubbles with o_valid=0, opcode 0.
   - Third cycle: o_sr2_val=0x42, o_valid=1, o_hazard_count=2.
4. Immediate masks hazard: i_ri=1, sr2=5 with bus0 pending, imm=0x7F -> no stall, o_sr2_val=0x7F.
5. Branch, then flush with hazard:
   - opcode 0x0C, dr=4 -> o_jmp_cond=4, o_dr=0.
   - Next, flush asserted during a hazard -> o_valid=0, o_opcode=0, counter unchanged, o_pipe_flush=1.
6. Counter saturation: counter preloaded near max (force), hazard held 3 cycles -> o_hazard_count=32'hFFFFFFFF. Then i_reset -> all outputs 0.
